wb_arb: RTL and testbench
=========================

# wb_arb

Round-robin Wishbone bus arbiter for the five DMA channel masters (channels 0–3 and the M channel, 4). It sits directly upstream of the channel mixer and produces the one-hot `gnt[4:0]` vector that steers the mixer's master-side multiplexers. A grant is held for a whole bus tenure, meaning for as long as the granted channel keeps `cyc` asserted. A one-cycle turnaround separates consecutive tenures. A stall watchdog forcibly revokes a grant when the bus stops responding.

## Interface
- `TIMEOUT`, default 256: number of consecutive stalled cycles that triggers revocation; 0 disables the watchdog.
- `CW`, default 9: stall-counter width; must satisfy `2**CW > TIMEOUT`.

- `wb_clk_i`  in  1  single clock; all logic on the rising edge.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `req`  in  5  `{wbs_cyc4,wbs_cyc3,wbs_cyc2,wbs_cyc1,wbs_cyc0}`, the per-channel bus requests.
- `wbm_stb_i`  in  1  muxed strobe returned from the mixer (`wbm_stb_o`).
- `wbm_ack_i`, `wbm_err_i`, `wbm_rty_i`  in  1 each  slave termination signals.
- `gnt`  out  5  one-hot grant, or all zeros; registered.
- `cur_id`  out  3  index of the current or last granted channel; registered.
- `busy`  out  1  high exactly when `gnt != 0`.
- `timeout_o`  out  1  one-cycle pulse on watchdog revocation.

## Operation
- **States:** IDLE, GRANT, TURN.
- **Reset values:** state=IDLE, `gnt`=0, `busy`=0, `timeout_o`=0, `cur_id`=0, round-robin pointer `last`=4, stall counter=0.
- **IDLE**
  - If `req` is zero, remain in IDLE.
  - Otherwise pick the first set bit of `req`, searching `last+1`, `last+2`, … modulo 5.
  - Load `gnt` with the one-hot value of that channel, `cur_id` with its index, and `last` with its index; go to GRANT.
- **GRANT**
  - `gnt` is held constant.
  - If `req[cur_id]` is 0, go to TURN and clear `gnt`.
  - Otherwise, if the watchdog fires, go to TURN, clear `gnt`, and pulse `timeout_o`.
  - Otherwise remain in GRANT.
  - Requests from other channels never preempt the current grant.
- **TURN**
  - `gnt` is 0 for exactly one cycle, then go to IDLE unconditionally.
  - This gives the registered mixer outputs one idle cycle with `cyc` low between tenures.
- **Watchdog** (only when `TIMEOUT` != 0)
  - The counter increments in GRANT on each cycle where `wbm_stb_i & ~(wbm_ack_i|wbm_err_i|wbm_rty_i)`.
  - It clears on any termination, on leaving GRANT, and on reset.
  - When the counter equals `TIMEOUT-1` and the current cycle is also stalled, the watchdog fires; the revocation takes effect at that edge.
  - Counter arithmetic is unsigned `CW`-bit; it never wraps, because firing ends the tenure.
- **Revoked channel:** remains eligible again only by round-robin order. Its `cyc` may still be high when the arbiter returns to IDLE; it is treated as a normal request.
- **`cur_id`:** holds its value through TURN and IDLE.
- **Invariant:** `gnt` is never multi-hot.

## Timing
- **Grant latency:** `req` rising sampled at edge N in IDLE gives `gnt` valid after edge N, i.e. one cycle.
- **Release:** `req[cur_id]` low sampled at edge N gives `gnt`=0 after N; TURN occupies N..N+1; IDLE samples at N+2; the next `gnt` appears after N+2.
  - Minimum gap between tenures: two cycles with `gnt`=0.
- **Simultaneous release and watchdog fire at the same edge:** treated as a normal release; `timeout_o` stays 0.
- **Termination on the same cycle the counter reaches its limit:** no fire; the counter clears.
- **`timeout_o`:** high for exactly the first TURN cycle.
- **Reset mid-tenure:** `gnt`=0 after the reset edge; the next grant search starts at channel 0.

## Test plan
- **Single request:** after reset, `req`=00100 from cycle 3 → `gnt`=00100 from cycle 4, `cur_id`=2. Drop `req` at cycle 10 → `gnt`=0 from cycle 11, and stays 0 while `req`=0.
- **Round-robin order:** hold `req`=11111; each channel drops its `cyc` for one cycle after 4 granted cycles, then re-raises it → grant order 0,1,2,3,4,0. Each tenure is followed by exactly two `gnt`=0 cycles.
- **No preemption:** ch3 granted; ch0 and ch4 raise `req` mid-tenure → `gnt` stays 01000 until ch3 releases, then 10000 (ch4) is granted before ch0.
- **Watchdog fire:** `TIMEOUT`=8, ch1 granted, `wbm_stb_i`=1, no ack → `timeout_o` pulses on the cycle after the 8th stalled cycle, `gnt` drops; with `req`=00110, ch2 is granted next.
- **Watchdog clear:** `TIMEOUT`=8, ack every 7th cycle over 100 cycles → `timeout_o` never asserts. Ack on the 8th stalled cycle → no fire.
- **Reset mid-tenure:** ch3 granted; `wb_rst_i`=1 for one cycle; `req`=11111 → `gnt`=0 after the reset edge, then `gnt`=00001 one cycle after reset deasserts.

Source files
------------

// File: rtl/wb_arb_if.sv
// Bus-side signals between the five DMA channel masters,
// the channel mixer and the round-robin arbiter.
interface wb_arb_if;
   logic [4:0] req;
   logic       wbm_stb_i;
   logic       wbm_ack_i;
   logic       wbm_err_i;
   logic       wbm_rty_i;
   logic [4:0] gnt;
   logic [2:0] cur_id;
   logic       busy;
   logic       timeout_o;

   modport master (
      output req, wbm_stb_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
      input  gnt, cur_id, busy, timeout_o
   );

   modport slave (
      input  req, wbm_stb_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
      output gnt, cur_id, busy, timeout_o
   );
endinterface

// File: rtl/wb_arb.sv
// Round-robin Wishbone arbiter for five DMA channels with
// whole-tenure grants, a turnaround cycle and a stall watchdog.
module wb_arb #(
   parameter int TIMEOUT = 256,
   parameter int CW      = 9
) (
   input logic     wb_clk_i,
   input logic     wb_rst_i,
   wb_arb_if.slave bus
);
   typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

   localparam bit WD_EN = (TIMEOUT != 0);
   localparam logic [CW-1:0] LIMIT =
      CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t        state, state_n;
   logic [4:0]    gnt, gnt_n;
   logic [2:0]    cur_id, cur_n;
   logic [2:0]    last, last_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          tmo, tmo_n;

   logic [9:0]    req2;
   logic [3:0]    k;
   logic [2:0]    pick;
   logic          found;
   logic          term, stall, fire;

   assign term  = bus.wbm_ack_i | bus.wbm_err_i | bus.wbm_rty_i;
   assign stall = bus.wbm_stb_i & ~term;
   assign fire  = WD_EN & stall & (cnt == LIMIT);
   assign req2  = {bus.req, bus.req};

   // Search last+1 .. last+5 over a doubled request vector
   always_comb begin
      pick  = '0;
      found = 1'b0;
      k     = '0;
      for (int i = 1; i <= 5; i++) begin
         k = {1'b0, last} + 4'(i);
         if (!found && req2[k]) begin
            found = 1'b1;
            pick  = (k >= 4'd5) ? 3'(k - 4'd5) : k[2:0];
         end
      end
   end

   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      cur_n   = cur_id;
      last_n  = last;
      cnt_n   = cnt;
      tmo_n   = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_n = '0;
            if (found) begin
               gnt_n   = 5'b00001 << pick;
               cur_n   = pick;
               last_n  = pick;
               state_n = GRANT;
            end
         end
         GRANT: begin
            if (!bus.req[cur_id]) begin
               gnt_n   = '0;
               cnt_n   = '0;
               state_n = TURN;
            end else if (fire) begin
               gnt_n   = '0;
               cnt_n   = '0;
               tmo_n   = 1'b1;
               state_n = TURN;
            end else if (term) begin
               cnt_n = '0;
            end else if (WD_EN && stall) begin
               cnt_n = cnt + CW'(1);
            end
         end
         TURN: begin
            gnt_n   = '0;
            cnt_n   = '0;
            state_n = IDLE;
         end
         default: begin
            gnt_n   = '0;
            cnt_n   = '0;
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state  <= IDLE;
         gnt    <= '0;
         cur_id <= '0;
         last   <= 3'd4;
         cnt    <= '0;
         tmo    <= 1'b0;
      end else begin
         state  <= state_n;
         gnt    <= gnt_n;
         cur_id <= cur_n;
         last   <= last_n;
         cnt    <= cnt_n;
         tmo    <= tmo_n;
      end
   end

   assign bus.gnt       = gnt;
   assign bus.cur_id    = cur_id;
   assign bus.busy      = |gnt;
   assign bus.timeout_o = tmo;
endmodule

// File: tb/tb_wb_arb.sv
// Self-checking bench for wb_arb: directed scenarios plus random
// traffic compared against a tenure-level reference model.
module tb_wb_arb;
   localparam int TMO = 8;

   logic wb_clk_i = 1'b0;
   logic wb_rst_i = 1'b1;
   int   tests = 0;
   int   fails = 0;

   wb_arb_if bus ();

   wb_arb #(.TIMEOUT(TMO), .CW(9)) dut (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .bus      (bus.slave)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   // Reference model: owner channel, remaining turnaround cycles,
   // current stall run and round-robin pointer
   int m_owner = -1;
   int m_gap   = 0;
   int m_ptr   = 4;
   int m_stall = 0;
   int m_cur   = 0;
   bit m_tmo   = 1'b0;

   always @(posedge wb_clk_i) begin
      bit st;
      bit tm;
      tm = bus.wbm_ack_i | bus.wbm_err_i | bus.wbm_rty_i;
      st = bus.wbm_stb_i & !tm;
      if (wb_rst_i) begin
         m_owner = -1; m_gap = 0; m_ptr = 4;
         m_stall = 0;  m_cur = 0; m_tmo = 1'b0;
      end else begin
         m_tmo = 1'b0;
         if (m_owner >= 0) begin
            if (!bus.req[m_owner]) begin
               m_owner = -1; m_gap = 1; m_stall = 0;
            end else if (st && m_stall + 1 == TMO) begin
               m_owner = -1; m_gap = 1; m_stall = 0; m_tmo = 1'b1;
            end else if (tm) m_stall = 0;
            else if (st) m_stall++;
         end else if (m_gap > 0) begin
            m_gap--;
         end else begin
            for (int j = 1; j <= 5; j++) begin
               int c;
               c = (m_ptr + j) % 5;
               if (bus.req[c]) begin
                  m_owner = c; m_cur = c; m_ptr = c; m_stall = 0;
                  break;
               end
            end
         end
      end
   end

   function automatic logic [9:0] exp_vec();
      logic [4:0] g;
      g = (m_owner >= 0) ? 5'(1 << m_owner) : 5'd0;
      return {g, 3'(m_cur), m_owner >= 0, m_tmo};
   endfunction

   task automatic step();
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic idle_bus();
      bus.req = '0; bus.wbm_stb_i = 1'b0; bus.wbm_ack_i = 1'b0;
      bus.wbm_err_i = 1'b0; bus.wbm_rty_i = 1'b0;
      repeat (3) step();
   endtask

   task automatic test_reset();
      wb_rst_i = 1'b1;
      idle_bus();
      tests++;
      if ({bus.gnt, bus.cur_id, bus.busy, bus.timeout_o} !== 10'd0) begin
         fails++;
         $display("FAIL reset: got gnt=%b id=%0d busy=%b tmo=%b exp all 0",
                  bus.gnt, bus.cur_id, bus.busy, bus.timeout_o);
      end
      wb_rst_i = 1'b0;
      step();
   endtask

   task automatic test_single();
      bus.req = 5'b00100;
      step();
      tests++;
      if (bus.gnt !== 5'b00100 || bus.cur_id !== 3'd2 || bus.busy !== 1'b1) begin
         fails++;
         $display("FAIL single_grant: got gnt=%b id=%0d busy=%b exp 00100/2/1",
                  bus.gnt, bus.cur_id, bus.busy);
      end
      repeat (5) step();
      bus.req = '0;
      for (int i = 0; i < 4; i++) begin
         step();
         tests++;
         if (bus.gnt !== 5'b0 || bus.busy !== 1'b0 || bus.cur_id !== 3'd2) begin
            fails++;
            $display("FAIL single_release[%0d]: got gnt=%b busy=%b id=%0d exp 0/0/2",
                     i, bus.gnt, bus.busy, bus.cur_id);
         end
      end
   endtask

   task automatic test_round_robin();
      int order[$];
      int exp_order[6] = '{0, 1, 2, 3, 4, 0};
      int held;
      int zeros;
      bit was_busy;
      wb_rst_i = 1'b1;
      idle_bus();
      wb_rst_i = 1'b0;
      bus.req = 5'b11111;
      held = 0; zeros = 0; was_busy = 1'b0;
      for (int c = 0; c < 80 && order.size() < 6; c++) begin
         step();
         tests++;
         if ({bus.gnt, bus.cur_id, bus.busy, bus.timeout_o} !== exp_vec()) begin
            fails++;
            $display("FAIL rr_model: got gnt=%b id=%0d exp %b", bus.gnt,
                     bus.cur_id, exp_vec());
         end
         bus.req = 5'b11111;
         if (bus.gnt != 5'b0) begin
            if (!was_busy) begin
               order.push_back(int'(bus.cur_id));
               if (order.size() > 1) begin
                  tests++;
                  if (zeros != 2) begin
                     fails++;
                     $display("FAIL rr_gap: got %0d idle cycles exp 2", zeros);
                  end
               end
               held = 0;
            end
            held++;
            if (held == 4) bus.req[bus.cur_id] = 1'b0;
            was_busy = 1'b1;
            zeros = 0;
         end else begin
            zeros++;
            was_busy = 1'b0;
         end
      end
      tests++;
      if (order.size() != 6) begin
         fails++;
         $display("FAIL rr_count: got %0d tenures exp 6", order.size());
      end
      for (int i = 0; i < order.size() && i < 6; i++) begin
         tests++;
         if (order[i] != exp_order[i]) begin
            fails++;
            $display("FAIL rr_order[%0d]: got ch%0d exp ch%0d", i, order[i],
                     exp_order[i]);
         end
      end
      idle_bus();
   endtask

   task automatic test_no_preempt();
      bus.req = 5'b01000;
      step();
      tests++;
      if (bus.gnt !== 5'b01000) begin
         fails++;
         $display("FAIL np_grant: got %b exp 01000", bus.gnt);
      end
      bus.req = 5'b11001;
      for (int i = 0; i < 5; i++) begin
         step();
         tests++;
         if (bus.gnt !== 5'b01000) begin
            fails++;
            $display("FAIL np_hold[%0d]: got %b exp 01000", i, bus.gnt);
         end
      end
      bus.req = 5'b10001;
      repeat (2) step();
      tests++;
      if (bus.gnt !== 5'b0) begin
         fails++;
         $display("FAIL np_turn: got %b exp 00000", bus.gnt);
      end
      step();
      tests++;
      if (bus.gnt !== 5'b10000 || bus.cur_id !== 3'd4) begin
         fails++;
         $display("FAIL np_next: got gnt=%b id=%0d exp 10000/4", bus.gnt,
                  bus.cur_id);
      end
      idle_bus();
   endtask

   task automatic test_watchdog_fire();
      bus.req = 5'b00010;
      step();
      tests++;
      if (bus.gnt !== 5'b00010) begin
         fails++;
         $display("FAIL wd_grant: got %b exp 00010", bus.gnt);
      end
      bus.wbm_stb_i = 1'b1;
      bus.req = 5'b00110;
      for (int i = 1; i < TMO; i++) begin
         step();
         tests++;
         if (bus.gnt !== 5'b00010 || bus.timeout_o !== 1'b0) begin
            fails++;
            $display("FAIL wd_stall[%0d]: got gnt=%b tmo=%b exp 00010/0", i,
                     bus.gnt, bus.timeout_o);
         end
      end
      step();
      tests++;
      if (bus.gnt !== 5'b0 || bus.timeout_o !== 1'b1) begin
         fails++;
         $display("FAIL wd_fire: got gnt=%b tmo=%b exp 00000/1", bus.gnt,
                  bus.timeout_o);
      end
      step();
      tests++;
      if (bus.gnt !== 5'b0 || bus.timeout_o !== 1'b0) begin
         fails++;
         $display("FAIL wd_pulse: got gnt=%b tmo=%b exp 00000/0", bus.gnt,
                  bus.timeout_o);
      end
      step();
      tests++;
      if (bus.gnt !== 5'b00100) begin
         fails++;
         $display("FAIL wd_next: got %b exp 00100", bus.gnt);
      end
      idle_bus();
   endtask

   task automatic test_watchdog_clear();
      bus.req = 5'b00001;
      step();
      bus.wbm_stb_i = 1'b1;
      for (int i = 0; i < 100; i++) begin
         bus.wbm_ack_i = (i % 7 == 6);
         step();
         tests++;
         if (bus.gnt !== 5'b00001 || bus.timeout_o !== 1'b0) begin
            fails++;
            $display("FAIL wdc_periodic[%0d]: got gnt=%b tmo=%b exp 00001/0",
                     i, bus.gnt, bus.timeout_o);
         end
      end
      bus.wbm_ack_i = 1'b1;
      step();
      bus.wbm_ack_i = 1'b0;
      repeat (TMO - 1) step();
      bus.wbm_ack_i = 1'b1;
      step();
      tests++;
      if (bus.gnt !== 5'b00001 || bus.timeout_o !== 1'b0) begin
         fails++;
         $display("FAIL wdc_limit_ack: got gnt=%b tmo=%b exp 00001/0",
                  bus.gnt, bus.timeout_o);
      end
      bus.wbm_ack_i = 1'b0;
      repeat (TMO - 1) step();
      tests++;
      if (bus.gnt !== 5'b00001 || bus.timeout_o !== 1'b0) begin
         fails++;
         $display("FAIL wdc_restart: got gnt=%b tmo=%b exp 00001/0",
                  bus.gnt, bus.timeout_o);
      end
      step();
      tests++;
      if (bus.gnt !== 5'b0 || bus.timeout_o !== 1'b1) begin
         fails++;
         $display("FAIL wdc_fire: got gnt=%b tmo=%b exp 00000/1", bus.gnt,
                  bus.timeout_o);
      end
      idle_bus();
   endtask

   task automatic test_reset_mid();
      bus.req = 5'b01000;
      repeat (3) step();
      tests++;
      if (bus.gnt !== 5'b01000) begin
         fails++;
         $display("FAIL rm_grant: got %b exp 01000", bus.gnt);
      end
      wb_rst_i = 1'b1;
      bus.req = 5'b11111;
      step();
      tests++;
      if (bus.gnt !== 5'b0 || bus.cur_id !== 3'd0) begin
         fails++;
         $display("FAIL rm_reset: got gnt=%b id=%0d exp 00000/0", bus.gnt,
                  bus.cur_id);
      end
      wb_rst_i = 1'b0;
      step();
      tests++;
      if (bus.gnt !== 5'b00001) begin
         fails++;
         $display("FAIL rm_first: got %b exp 00001", bus.gnt);
      end
      idle_bus();
   endtask

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         for (int b = 0; b < 5; b++)
            if ($urandom_range(7) == 0) bus.req[b] = ~bus.req[b];
         bus.wbm_stb_i = ($urandom_range(3) != 0);
         bus.wbm_ack_i = ($urandom_range(19) == 0);
         bus.wbm_err_i = ($urandom_range(39) == 0);
         bus.wbm_rty_i = ($urandom_range(39) == 0);
         wb_rst_i = ($urandom_range(299) == 0);
         step();
         tests++;
         if ({bus.gnt, bus.cur_id, bus.busy, bus.timeout_o} !== exp_vec()
             || !$onehot0(bus.gnt)) begin
            fails++;
            $display("FAIL random[%0d]: got gnt=%b id=%0d busy=%b tmo=%b exp %b",
                     c, bus.gnt, bus.cur_id, bus.busy, bus.timeout_o, exp_vec());
         end
      end
      wb_rst_i = 1'b0;
      idle_bus();
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "time limit");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_no_preempt();
      test_watchdog_fire();
      test_watchdog_clear();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
